imem_fetch_queue: RTL and testbench

//   Parametrised instruction memory with synchronous read, a loader write port and a

---
 rtl/imem_fetch_queue.sv | 118 +++++++++++
 tb/tb_imem_fetch_queue.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_queue.sv
// Instruction memory with a synchronous read port, a loader write port and a small
// response queue, so that fetch can stall or flush without losing or repeating words.
module imem_fetch_queue #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 4096,
  parameter int unsigned       Q_DEPTH   = 2,
  parameter logic [DATA_W-1:0] NOP_WORD  = '0,
  parameter string             INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_fault,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned QW = $clog2(Q_DEPTH);
  localparam int unsigned CW = QW + 1;
  localparam logic [CW:0] QLim = (CW + 1)'(Q_DEPTH);

  typedef enum logic [0:0] {StIdle, StReadPending} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [QW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic              pend_fault_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] q_instr [Q_DEPTH];
  logic [ADDR_W-1:0] q_addr  [Q_DEPTH];
  logic              q_fault [Q_DEPTH];

  logic          req_fault, ld_fault, inflight, accept, push, pop;
  logic [IW-1:0] req_idx, ld_idx;
  logic [CW:0]   occ;

  // Misaligned or beyond the last word; the shift keeps this legal for any ADDR_W.
  assign req_fault = (req_addr[1:0] != 2'b00) || ((req_addr >> (IW + 2)) != '0);
  assign ld_fault  = (ld_addr[1:0] != 2'b00) || ((ld_addr >> (IW + 2)) != '0);
  assign req_idx   = req_addr[IW+1:2];
  assign ld_idx    = ld_addr[IW+1:2];

  assign inflight  = (state_q == StReadPending);
  assign occ       = {1'b0, count_q} + {{CW{1'b0}}, inflight};
  assign req_ready = !ld_en && !flush && (occ < QLim);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign push      = inflight && !flush;
  assign busy      = inflight || rsp_valid;

  assign rsp_instr = rsp_valid ? q_instr[rd_ptr_q] : '0;
  assign rsp_addr  = rsp_valid ? q_addr[rd_ptr_q]  : '0;
  assign rsp_fault = rsp_valid ? q_fault[rd_ptr_q] : 1'b0;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (flush) begin
      state_d = StIdle;
      count_d = '0;
    end else begin
      state_d = accept ? StReadPending : StIdle;
      count_d = count_q + {{QW{1'b0}}, push} - {{QW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pend_addr_q  <= '0;
      pend_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (accept) begin
        pend_addr_q  <= req_addr;
        pend_fault_q <= req_fault;
      end
    end
  end

  // Storage needs no reset; validity is tracked entirely by count_q and state_q.
  always_ff @(posedge clk) begin
    if (ld_en && !ld_fault)   mem[ld_idx] <= ld_data;
    if (accept && !req_fault) rd_data_q   <= mem[req_idx];
    if (push) begin
      q_instr[wr_ptr_q] <= pend_fault_q ? NOP_WORD : rd_data_q;
      q_addr[wr_ptr_q]  <= pend_addr_q;
      q_fault[wr_ptr_q] <= pend_fault_q;
    end
  end

endmodule

// File: tb/tb_imem_fetch_queue.sv
// Directed bench for imem_fetch_queue: per-cycle vector table for the main stream,
// plus hand sequences for backpressure, flush and mid-stream reset.
module tb_imem_fetch_queue;

  localparam logic [31:0] WA  = 32'h1111_0001;
  localparam logic [31:0] WB  = 32'h2222_0002;
  localparam logic [31:0] WC  = 32'h3333_0003;
  localparam logic [31:0] WD  = 32'h4444_0004;
  localparam logic [31:0] WE  = 32'h5555_0005;
  localparam logic [31:0] WF  = 32'h2001_0005;
  localparam logic [31:0] WX  = 32'hDEAD_BEEF;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault, flush, ld_en, busy;
  logic [31:0] req_addr, rsp_instr, rsp_addr, ld_addr, ld_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_fetch_queue #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .DEPTH   (4096),
    .Q_DEPTH (2),
    .NOP_WORD(NOP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr),
    .rsp_addr (rsp_addr),
    .rsp_fault(rsp_fault),
    .flush    (flush),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .busy     (busy)
  );

  typedef struct {
    logic        req_valid;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_addr;
    logic        e_fault;
    logic        e_busy;
  } vec_t;

  vec_t vt[22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t ld_row(input logic [31:0] a, input logic [31:0] d);
    vec_t v;
    v = '{req_valid: 1'b0, req_addr: 32'h0, rsp_ready: 1'b1, ld_en: 1'b1, ld_addr: a,
          ld_data: d, e_ready: 1'b0, e_valid: 1'b0, e_instr: 32'h0, e_addr: 32'h0,
          e_fault: 1'b0, e_busy: 1'b0};
    return v;
  endfunction

  function automatic vec_t rq_row(input logic v_in, input logic [31:0] a, input logic er,
                                  input logic ev, input logic [31:0] ei,
                                  input logic [31:0] ea, input logic ef, input logic eb);
    vec_t v;
    v = '{req_valid: v_in, req_addr: a, rsp_ready: 1'b1, ld_en: 1'b0, ld_addr: 32'h0,
          ld_data: 32'h0, e_ready: er, e_valid: ev, e_instr: ei, e_addr: ea,
          e_fault: ef, e_busy: eb};
    return v;
  endfunction

  // Drive one request until accepted, then wait for and take its response.
  task automatic fetch_one(input logic [31:0] a, output logic [31:0] d, output logic f,
                           output bit ok);
    ok        = 1'b0;
    d         = '0;
    f         = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = a;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int c = 0; c < 10; c++) begin
        #1;
        if (rsp_valid) begin
          d = rsp_instr;
          f = rsp_fault;
          @(posedge clk); #1;
          ok = 1'b1;
          break;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] seq_addr[4];
    logic [31:0] seq_data[4];
    logic [31:0] rec[4];
    logic [31:0] d;
    logic        f;
    bit          ok, fire, take;
    int          idx, acc, got;

    seq_addr = '{32'd0, 32'd4, 32'd8, 32'd12};
    seq_data = '{WA, WB, WC, WD};
    rec      = '{32'h0, 32'h0, 32'h0, 32'h0};

    vt[0]  = ld_row(32'd0, WA);
    vt[1]  = ld_row(32'd4, WB);
    vt[2]  = ld_row(32'd8, WC);
    vt[3]  = ld_row(32'd12, WD);
    vt[4]  = ld_row(32'd2, WX);      // misaligned, must not touch word 0
    vt[5]  = ld_row(32'd16384, WX);  // out of range, must not alias word 0
    vt[6]  = ld_row(32'd4092, WE);
    vt[7]  = ld_row(32'd4096, WF);
    vt[8]  = rq_row(1, 32'd0,     1, 0, 32'h0, 32'd0,     0, 0);
    vt[9]  = rq_row(1, 32'd4,     1, 0, 32'h0, 32'd0,     0, 1);
    vt[10] = rq_row(1, 32'd8,     0, 1, WA,    32'd0,     0, 1);
    vt[11] = rq_row(1, 32'd8,     1, 1, WB,    32'd4,     0, 1);
    vt[12] = rq_row(1, 32'd12,    1, 0, 32'h0, 32'd0,     0, 1);
    vt[13] = rq_row(1, 32'd6,     0, 1, WC,    32'd8,     0, 1);
    vt[14] = rq_row(1, 32'd6,     1, 1, WD,    32'd12,    0, 1);
    vt[15] = rq_row(1, 32'd16384, 1, 0, 32'h0, 32'd0,     0, 1);
    vt[16] = rq_row(1, 32'd4092,  0, 1, NOP,   32'd6,     1, 1);
    vt[17] = rq_row(1, 32'd4092,  1, 1, NOP,   32'd16384, 1, 1);
    vt[18] = rq_row(1, 32'd4096,  1, 0, 32'h0, 32'd0,     0, 1);
    vt[19] = rq_row(0, 32'd0,     0, 1, WE,    32'd4092,  0, 1);
    vt[20] = rq_row(0, 32'd0,     1, 1, WF,    32'd4096,  0, 1);
    vt[21] = rq_row(0, 32'd0,     1, 0, 32'h0, 32'd0,     0, 0);

    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    flush     = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_instr", rsp_instr, 0);
    chk("reset_rsp_addr", rsp_addr, 0);
    chk("reset_rsp_fault", rsp_fault, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("release_req_ready", req_ready, 1);

    // Vector table: loader writes, then a fetch stream with faults and full stalls.
    for (int i = 0; i < 22; i++) begin
      req_valid = vt[i].req_valid;
      req_addr  = vt[i].req_addr;
      rsp_ready = vt[i].rsp_ready;
      ld_en     = vt[i].ld_en;
      ld_addr   = vt[i].ld_addr;
      ld_data   = vt[i].ld_data;
      #1;
      chk($sformatf("vec%0d_req_ready", i), req_ready, vt[i].e_ready);
      chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, vt[i].e_valid);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
      if (vt[i].e_valid) begin
        chk($sformatf("vec%0d_rsp_instr", i), rsp_instr, vt[i].e_instr);
        chk($sformatf("vec%0d_rsp_addr", i), rsp_addr, vt[i].e_addr);
        chk($sformatf("vec%0d_rsp_fault", i), rsp_fault, vt[i].e_fault);
      end
      @(posedge clk); #1;
    end
    ld_en = 1'b0;

    // Backpressure: two accepts fill the queue, head holds A, then drain in order.
    rsp_ready = 1'b0;
    idx = 0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1;
      req_addr  = seq_addr[idx];
      #1;
      fire = req_ready;
      if (c >= 2) begin
        chk($sformatf("bp_valid_c%0d", c), rsp_valid, 1);
        chk($sformatf("bp_head_c%0d", c), rsp_instr, WA);
      end
      if (c == 5) chk("bp_ready_low", req_ready, 0);
      @(posedge clk); #1;
      if (fire) begin
        acc++;
        idx++;
      end
    end
    chk("bp_accepts", acc, 2);
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      req_valid = (idx < 4);
      req_addr  = (idx < 4) ? seq_addr[idx] : 32'h0;
      #1;
      fire = req_valid && req_ready;
      take = rsp_valid;
      if (take) rec[got] = rsp_instr;
      @(posedge clk); #1;
      if (fire) idx++;
      if (take) got++;
    end
    req_valid = 1'b0;
    chk("bp_resp_count", got, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("bp_order_%0d", k), rec[k], seq_data[k]);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained_valid", rsp_valid, 0);
    chk("bp_drained_busy", busy, 0);

    // Flush with one entry queued and one read in flight.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'd0;
    @(posedge clk); #1;
    req_addr  = 32'd4;
    @(posedge clk); #1;
    chk("pre_flush_valid", rsp_valid, 1);
    chk("pre_flush_head", rsp_instr, WA);
    flush    = 1'b1;
    req_addr = 32'd8;
    #1;
    chk("flush_req_ready", req_ready, 0);
    @(posedge clk); #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("post_flush_valid", rsp_valid, 0);
    chk("post_flush_busy", busy, 0);
    fetch_one(32'd0, d, f, ok);
    chk("flush_fetch_ok", ok, 1);
    chk("flush_fetch_data", d, WA);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("flush_no_extra_%0d", c), rsp_valid, 0);
      @(posedge clk); #1;
    end

    // Asynchronous reset with two entries queued; memory contents must survive.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'd0;
    @(posedge clk); #1;
    req_addr  = 32'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_valid", rsp_valid, 1);
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("async_reset_valid", rsp_valid, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_instr", rsp_instr, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    fetch_one(32'd4096, d, f, ok);
    chk("retain_4096_ok", ok, 1);
    chk("retain_4096_data", d, WF);
    chk("retain_4096_fault", f, 0);
    fetch_one(32'd0, d, f, ok);
    chk("retain_0_ok", ok, 1);
    chk("retain_0_data", d, WA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
